// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: forwarding-select encodings shared by the controller and the ID/EX bypass muxes
package pipe_ctrl_pkg;
   typedef logic [1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_EX  = 2'b01;
   localparam fwd_sel_t FWD_MEM = 2'b10;
   localparam fwd_sel_t FWD_WB  = 2'b11;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage hazard inputs and pipeline control outputs of the controller
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(parameter int REG_AW = 5, parameter int CNT_W = 32);
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic              id_rs1_used_i;
   logic              id_rs2_used_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_rf_wen_i;
   logic              id_load_i;
   logic              id_branch_i;
   logic              id_exit_i;
   logic              ex_busy_i;
   logic              pc_stall_o;
   logic              if_id_stall_o;
   logic              if_id_flush_o;
   logic              id_ex_bubble_o;
   logic              ex_stall_o;
   fwd_sel_t          fwd_rs1_sel_o;
   fwd_sel_t          fwd_rs2_sel_o;
   logic              ex_valid_o;
   logic              mem_valid_o;
   logic              wb_valid_o;
   logic              halt_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i,
             id_rf_wen_i, id_load_i, id_branch_i, id_exit_i, ex_busy_i,
      input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_stall_o,
             fwd_rs1_sel_o, fwd_rs2_sel_o, ex_valid_o, mem_valid_o, wb_valid_o, halt_o, stall_cnt_o
   );
   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_rd_i,
             id_rf_wen_i, id_load_i, id_branch_i, id_exit_i, ex_busy_i,
      output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_bubble_o, ex_stall_o,
             fwd_rs1_sel_o, fwd_rs2_sel_o, ex_valid_o, mem_valid_o, wb_valid_o, halt_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_track_stage.sv
// pipe_track_stage: per-stage valid/rd/wen/load/exit tracking register with hold and bubble
module pipe_track_stage #(parameter int REG_AW = 5) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hold,
   input  logic              bubble,
   input  logic              valid_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              wen_i,
   input  logic              load_i,
   input  logic              exit_i,
   output logic              valid_o,
   output logic [REG_AW-1:0] rd_o,
   output logic              wen_o,
   output logic              load_o,
   output logic              exit_o
);
   localparam int W = REG_AW + 4;
   logic [W-1:0] st_d, st_q;
   // Hold keeps the current entry, bubble inserts an empty one, otherwise take the upstream stage
   always_comb begin
      st_d = hold ? st_q : bubble ? '0 : {valid_i, rd_i, wen_i, load_i, exit_i};
   end
   // Stage register, cleared by reset so no in-flight write survives
   always_ff @(posedge clock) begin
      if (reset) st_q <= '0;
      else st_q <= st_d;
   end
   assign {valid_o, rd_o, wen_o, load_o, exit_o} = st_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard detection, forwarding, stall/flush control, halt and stall counting for the 5-stage core
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(parameter int REG_AW = 5, parameter int FWD_EN = 1, parameter int CNT_W = 32) (
   input  logic       clock,
   input  logic       reset,
   pipe_ctrl_if.slave bus
);
   logic              ex_v, ex_w, ex_l, ex_x, mem_v, mem_w, mem_l, mem_x, wb_v, wb_w, wb_l, wb_x;
   logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
   logic              id_v, u1, u2, e1, e2, m1, m2, w1, w2, raw, hz, hold, bubble;
   fwd_sel_t          sel1, sel2;
   logic              halt_d, halt_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic              unused_wb_load;

   function automatic logic hit(input logic v, input logic w, input logic [REG_AW-1:0] rd,
                                input logic [REG_AW-1:0] src, input logic used);
      return v & w & (rd != '0) & (rd == src) & used;
   endfunction

   assign id_v = bus.id_valid_i;
   assign u1 = id_v & bus.id_rs1_used_i;
   assign u2 = id_v & bus.id_rs2_used_i;
   assign e1 = hit(ex_v, ex_w, ex_rd, bus.id_rs1_i, u1);
   assign e2 = hit(ex_v, ex_w, ex_rd, bus.id_rs2_i, u2);
   assign m1 = hit(mem_v, mem_w, mem_rd, bus.id_rs1_i, u1);
   assign m2 = hit(mem_v, mem_w, mem_rd, bus.id_rs2_i, u2);
   assign w1 = hit(wb_v, wb_w, wb_rd, bus.id_rs1_i, u1);
   assign w2 = hit(wb_v, wb_w, wb_rd, bus.id_rs2_i, u2);
   assign unused_wb_load = wb_l;

   // Hazards: busy EX wins over RAW stalls, halt freezes fetch and drains, flush only when ID moves
   always_comb begin
      raw = (FWD_EN != 0) ? ((e1 | e2) & ex_l) : (e1 | e2 | m1 | m2 | w1 | w2);
      hz = raw & ~bus.ex_busy_i;
      hold = bus.ex_busy_i | hz | halt_q;
      bubble = hz | halt_q;
      sel1 = (FWD_EN == 0) ? FWD_RF : e1 ? FWD_EX : m1 ? FWD_MEM : w1 ? FWD_WB : FWD_RF;
      sel2 = (FWD_EN == 0) ? FWD_RF : e2 ? FWD_EX : m2 ? FWD_MEM : w2 ? FWD_WB : FWD_RF;
   end

   assign bus.pc_stall_o     = hold;
   assign bus.if_id_stall_o  = hold;
   assign bus.if_id_flush_o  = id_v & bus.id_branch_i & ~hold;
   assign bus.id_ex_bubble_o = bubble;
   assign bus.ex_stall_o     = bus.ex_busy_i;
   assign bus.fwd_rs1_sel_o  = sel1;
   assign bus.fwd_rs2_sel_o  = sel2;
   assign bus.ex_valid_o     = ex_v;
   assign bus.mem_valid_o    = mem_v;
   assign bus.wb_valid_o     = wb_v;
   assign bus.halt_o         = halt_q;
   assign bus.stall_cnt_o    = cnt_q;

   pipe_track_stage #(.REG_AW(REG_AW)) u_ex (
      .clock(clock), .reset(reset), .hold(bus.ex_busy_i), .bubble(bubble),
      .valid_i(id_v), .rd_i(id_v ? bus.id_rd_i : '0), .wen_i(id_v & bus.id_rf_wen_i),
      .load_i(id_v & bus.id_load_i), .exit_i(id_v & bus.id_exit_i),
      .valid_o(ex_v), .rd_o(ex_rd), .wen_o(ex_w), .load_o(ex_l), .exit_o(ex_x)
   );
   pipe_track_stage #(.REG_AW(REG_AW)) u_mem (
      .clock(clock), .reset(reset), .hold(1'b0), .bubble(bus.ex_busy_i),
      .valid_i(ex_v), .rd_i(ex_rd), .wen_i(ex_w), .load_i(ex_l), .exit_i(ex_x),
      .valid_o(mem_v), .rd_o(mem_rd), .wen_o(mem_w), .load_o(mem_l), .exit_o(mem_x)
   );
   pipe_track_stage #(.REG_AW(REG_AW)) u_wb (
      .clock(clock), .reset(reset), .hold(1'b0), .bubble(1'b0),
      .valid_i(mem_v), .rd_i(mem_rd), .wen_i(mem_w), .load_i(mem_l), .exit_i(mem_x),
      .valid_o(wb_v), .rd_o(wb_rd), .wen_o(wb_w), .load_o(wb_l), .exit_o(wb_x)
   );

   // Halt latches once exit retires; counter counts non-halted stall cycles and saturates
   always_comb begin
      halt_d = halt_q | (wb_v & wb_x);
      cnt_d = (hold & ~halt_q & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
   end

   // Halt and counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         halt_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         halt_q <= halt_d;
         cnt_q <= cnt_d;
      end
   end
endmodule
